uart_mem_target: RTL
====================

Name: uart_mem_target

Overview:
- UART-side responder for the UART memory-access link; the far end of the mem_uart initiator.
- Receives command frames on a UART RX line, performs one read or write on a local memory bus (valid/accept handshake), then returns an ack or read data on UART TX.
- Sits in front of on-chip RAM or a register file so a host or mem_uart can access it over a serial line.

Parameters:
DATA_WIDTH, 16, memory data width in bits; multiple of 8.
ADDR_WIDTH, 64, memory address width in bits; multiple of 8.
SAMPLE, 1250, clock cycles per UART bit (CLK_HZ/BAUD; 12 MHz / 9600).
TIMEOUT_BITS, 40, bit-times of RX silence mid-frame before the frame is aborted.

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_uart_rx  in  1  UART serial in, idle high
o_uart_tx  out  1  UART serial out, idle high
o_mem_addr  out  ADDR_WIDTH  memory address
o_mem_data  out  DATA_WIDTH  write data
i_mem_data  in  DATA_WIDTH  read data, valid on the accept cycle
o_mem_read_valid  out  1  read request
i_mem_read_accept  in  1  read completes
o_mem_write_valid  out  1  write request
i_mem_write_accept  in  1  write completes
o_frame_err  out  1  one-cycle pulse on framing error, timeout or bad command

Behaviour:
- Reset is asynchronous, active low, on i_nrst. Reset values:
  - o_uart_tx=1; o_mem_read_valid=0, o_mem_write_valid=0; o_frame_err=0.
  - o_mem_addr=0, o_mem_data=0.
  - All FSMs return to IDLE. Reset mid-frame or mid-transfer discards all state.
- RX path:
  - i_uart_rx passes through a 2-flop synchroniser.
  - A falling edge in RX_IDLE starts a bit counter. At SAMPLE/2 the start bit is rechecked; if high, return to idle with no error.
  - The 8 data bits are sampled every SAMPLE cycles at mid-bit, LSB first, followed by the stop bit.
  - Stop bit = 0: byte dropped, o_frame_err pulses, parser returns to CMD.
- Frame format:
  - Byte 0 is the command: 0x57 ('W') = write, 0x52 ('R') = read.
  - Then ADDR_WIDTH/8 address bytes, MSB first.
  - For a write only, DATA_WIDTH/8 data bytes follow, MSB first.
  - Defaults give 11 bytes per write frame and 9 per read frame.
- Parser FSM: CMD -> ADDR -> (DATA if write) -> MEM -> RESP -> CMD.
  - Any other command byte: send NAK 0x15, pulse o_frame_err, return to CMD after the NAK completes.
  - No byte completes within TIMEOUT_BITS*SAMPLE cycles while in ADDR or DATA: abort to CMD, pulse o_frame_err, send no response.
  - Bytes received in MEM or RESP are discarded silently.
- MEM state:
  - The matching valid is asserted the cycle after the last frame byte, with o_mem_addr and o_mem_data stable.
  - Valid is held until accept=1 is sampled on a rising edge. The transfer occurs on that edge; valid is 0 on the next cycle.
  - Read data is captured from i_mem_data on the accept edge.
  - No timeout applies to accept.
  - Accept inputs are ignored while the matching valid is low.
- RESP state:
  - Write: send ACK 0x06.
  - Read: send DATA_WIDTH/8 bytes of captured data, MSB first.
  - TX starts the cycle after entry; bytes go back-to-back with no idle gap beyond the stop bit.
- TX framing: start bit 0, 8 bits LSB first, stop bit 1, each exactly SAMPLE cycles; 10*SAMPLE cycles per byte.

Test Plan:
- Write 0xABCD to 0x0123456789ABCDEF: send frame 57 01 23 45 67 89 AB CD EF AB CD, hold i_mem_write_accept low 3 cycles then high. Expect o_mem_write_valid for 4 cycles with o_mem_addr=0x0123456789ABCDEF and o_mem_data=0xABCD, then TX byte 0x06.
- Read: send 52 00 00 00 00 00 00 00 10 and return i_mem_data=0xBEEF on accept. Expect o_mem_read_valid, o_mem_addr=0x10, then TX bytes BE, EF.
- Bad command: send 0x41. Expect TX 0x15, one o_frame_err pulse, no memory valid; a following valid write frame completes normally.
- Framing error: send byte 0x57 with stop bit 0. Expect o_frame_err pulse, no response; the next frame parses from CMD.
- Timeout: send 57 01 23 then stay idle 40 bit-times. Expect o_frame_err pulse, no memory access; a subsequent read frame succeeds.
- Reset mid-operation: assert i_nrst low during TX of a read response. Expect o_uart_tx=1 and all valids 0 immediately; after release, a fresh write frame succeeds.

Source files
------------

// File: rtl/uart_mem_target_if.sv
// Memory-side bus of the UART memory target.
// The target drives the request (master modport); the RAM or register file
// answers it (slave modport).
//   mem_addr         : request address
//   mem_wdata        : write data
//   mem_rdata        : read data, valid on the read-accept cycle
//   mem_read_valid   : read request, held until accepted
//   mem_read_accept  : read completes on the rising edge where it is seen high
//   mem_write_valid  : write request, held until accepted
//   mem_write_accept : write completes on the rising edge where it is seen high
interface uart_mem_target_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_read_valid;
  logic                  mem_read_accept;
  logic                  mem_write_valid;
  logic                  mem_write_accept;

  modport master (
    output mem_addr, mem_wdata, mem_read_valid, mem_write_valid,
    input  mem_rdata, mem_read_accept, mem_write_accept
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read_valid, mem_write_valid,
    output mem_rdata, mem_read_accept, mem_write_accept
  );
endinterface

// File: rtl/uart_mem_target.sv
// UART memory-access target: receives 'W'/'R' command frames on a UART RX
// line, runs one transfer on the local memory bus, and answers on UART TX
// (ACK 0x06 for a write, the read data MSB first for a read, NAK 0x15 for an
// unknown command).
//   i_clk, i_nrst : clock, asynchronous active-low reset
//   i_uart_rx     : serial in, idle high
//   o_uart_tx     : serial out, idle high
//   o_frame_err   : one-cycle pulse on bad stop bit, mid-frame timeout or bad command
//   mem           : memory request bus (master side)
module uart_mem_target #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 64,
  parameter int SAMPLE       = 1250,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_uart_rx,
  output logic              o_uart_tx,
  output logic              o_frame_err,
  uart_mem_target_if.master mem
);
  localparam int DATA_BYTES = DATA_WIDTH / 8;
  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam int CNT_W      = $clog2(SAMPLE);
  localparam int TMO_W      = $clog2(TIMEOUT_BITS * SAMPLE + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(SAMPLE - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SAMPLE / 2 - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_BITS * SAMPLE - 1);
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_MEM, P_RESP} p_state_e;

  // RX
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_byte_valid, rx_stop_err;

  // Parser / memory side
  p_state_e              p_state_q, p_state_d;
  logic                  is_write_q, is_write_d;
  logic [7:0]            byte_cnt_q, byte_cnt_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rd_valid_q, rd_valid_d, wr_valid_q, wr_valid_d;
  logic [DATA_WIDTH-1:0] resp_buf_q, resp_buf_d;
  logic [7:0]            resp_left_q, resp_left_d;
  logic                  err_q, err_d;

  // TX
  logic             tx_busy_q, tx_busy_d;
  logic [8:0]       tx_shift_q, tx_shift_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_done, tx_free, tx_load;

  always_comb begin
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_byte_valid = 1'b0;
    rx_stop_err   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          // A high line at mid start bit was a glitch: drop it silently.
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) rx_byte_valid = 1'b1;
          else           rx_stop_err   = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  assign tx_done = tx_busy_q && (tx_bit_q == 4'd9) && (tx_cnt_q == BIT_LAST);
  assign tx_free = !tx_busy_q || tx_done;

  always_comb begin
    p_state_d   = p_state_q;
    is_write_d  = is_write_q;
    byte_cnt_d  = byte_cnt_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_valid_d  = rd_valid_q;
    wr_valid_d  = wr_valid_q;
    resp_buf_d  = resp_buf_q;
    resp_left_d = resp_left_q;
    err_d       = rx_stop_err;
    tx_busy_d   = tx_busy_q;
    tx_shift_d  = tx_shift_q;
    tx_bit_d    = tx_bit_q;
    tx_cnt_d    = tx_cnt_q;
    tx_line_d   = tx_line_q;
    tx_load     = 1'b0;

    // Bit timing: tx_shift holds {stop, data} behind the start bit already on the line.
    if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b1, tx_shift_q[8:1]};
          tx_bit_d   = tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    end

    case (p_state_q)
      P_CMD: begin
        tmo_d      = '0;
        byte_cnt_d = '0;
        if (rx_byte_valid) begin
          if (rx_shift_q == CMD_WR || rx_shift_q == CMD_RD) begin
            is_write_d = (rx_shift_q == CMD_WR);
            p_state_d  = P_ADDR;
          end else begin
            err_d       = 1'b1;
            resp_buf_d  = '0;
            resp_buf_d[DATA_WIDTH-1 -: 8] = NAK;
            resp_left_d = 8'd1;
            p_state_d   = P_RESP;
          end
        end
      end
      P_ADDR, P_DATA: begin
        if (rx_stop_err) begin
          p_state_d = P_CMD;
        end else if (rx_byte_valid) begin
          tmo_d = '0;
          if (p_state_q == P_ADDR) begin
            addr_d = ADDR_WIDTH'({addr_q, rx_shift_q});
            if (byte_cnt_q == 8'(ADDR_BYTES - 1)) begin
              byte_cnt_d = '0;
              if (is_write_q) begin
                p_state_d = P_DATA;
              end else begin
                p_state_d  = P_MEM;
                rd_valid_d = 1'b1;
              end
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end else begin
            wdata_d = DATA_WIDTH'({wdata_q, rx_shift_q});
            if (byte_cnt_q == 8'(DATA_BYTES - 1)) begin
              p_state_d  = P_MEM;
              wr_valid_d = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d     = 1'b1;
          p_state_d = P_CMD;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      P_MEM: begin
        if (wr_valid_q && mem.mem_write_accept) begin
          wr_valid_d  = 1'b0;
          resp_buf_d  = '0;
          resp_buf_d[DATA_WIDTH-1 -: 8] = ACK;
          resp_left_d = 8'd1;
          p_state_d   = P_RESP;
        end else if (rd_valid_q && mem.mem_read_accept) begin
          rd_valid_d  = 1'b0;
          resp_buf_d  = mem.mem_rdata;
          resp_left_d = 8'(DATA_BYTES);
          p_state_d   = P_RESP;
        end
      end
      P_RESP: begin
        // Next byte is loaded on the very edge the previous stop bit ends.
        if (tx_free) begin
          if (resp_left_q != 8'd0) begin
            tx_load     = 1'b1;
            resp_buf_d  = DATA_WIDTH'({resp_buf_q, 8'h00});
            resp_left_d = resp_left_q - 8'd1;
          end else begin
            p_state_d = P_CMD;
          end
        end
      end
      default: p_state_d = P_CMD;
    endcase

    if (tx_load) begin
      tx_busy_d  = 1'b1;
      tx_line_d  = 1'b0;
      tx_shift_d = {1'b1, resp_buf_q[DATA_WIDTH-1 -: 8]};
      tx_bit_d   = '0;
      tx_cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      p_state_q   <= P_CMD;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= '0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      resp_buf_q  <= '0;
      resp_left_q <= '0;
      err_q       <= 1'b0;
      tx_busy_q   <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      tx_line_q   <= 1'b1;
    end else begin
      rx_meta_q   <= i_uart_rx;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      p_state_q   <= p_state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_valid_q  <= rd_valid_d;
      wr_valid_q  <= wr_valid_d;
      resp_buf_q  <= resp_buf_d;
      resp_left_q <= resp_left_d;
      err_q       <= err_d;
      tx_busy_q   <= tx_busy_d;
      tx_shift_q  <= tx_shift_d;
      tx_bit_q    <= tx_bit_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_line_q   <= tx_line_d;
    end
  end

  assign o_uart_tx           = tx_line_q;
  assign o_frame_err         = err_q;
  assign mem.mem_addr        = addr_q;
  assign mem.mem_wdata       = wdata_q;
  assign mem.mem_read_valid  = rd_valid_q;
  assign mem.mem_write_valid = wr_valid_q;
endmodule
